// File: rtl/logic_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package logic_pkg;

    localparam int LOGIC_OP_W = 3;

    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } logic_op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation select with zero and parity flags.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic_op_e          op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               parity
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = a;
        endcase
    end

    assign zero   = (y == '0);
    assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_core: S1 holds operands,
// S2 holds the result and its flags.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LOGIC_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_zero,
    output logic                  out_parity
);

    // Handshake: a transfer occurs on any rising edge where valid && ready are
    // both high on that port; the producer holds payload stable while valid is
    // high and ready is low, and ready never depends on the same port's valid.

    logic                  s1_valid;
    logic [LOGIC_OP_W-1:0] s1_op;
    logic [WIDTH-1:0]      s1_a;
    logic [WIDTH-1:0]      s1_b;
    logic [TAG_W-1:0]      s1_tag;

    logic                  s2_valid;
    logic [WIDTH-1:0]      s2_data;
    logic [TAG_W-1:0]      s2_tag;
    logic                  s2_zero;
    logic                  s2_parity;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [WIDTH-1:0]      core_y;
    logic                  core_zero;
    logic                  core_parity;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op     (logic_op_e'(s1_op)),
        .a      (s1_a),
        .b      (s1_b),
        .y      (core_y),
        .zero   (core_zero),
        .parity (core_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_tag    <= '0;
            s2_zero   <= 1'b0;
            s2_parity <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data   <= core_y;
                    s2_tag    <= s1_tag;
                    s2_zero   <= core_zero;
                    s2_parity <= core_parity;
                end
            end
            // Payload only reloads on a real transfer; stale values are harmless.
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op  <= in_op;
                    s1_a   <= in_a;
                    s1_b   <= in_b;
                    s1_tag <= in_tag;
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_data   = s2_data;
    assign out_tag    = s2_tag;
    assign out_zero   = s2_zero;
    assign out_parity = s2_parity;

endmodule
